// File: rtl/prog_loader_arbiter.sv
// Program-image loader for the 8-bit CPU RAM: holds the CPU at an instruction
// boundary, streams DEPTH bytes in, verifies them by readback XOR, then releases.
module prog_loader_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_req,
  input  logic              cpu_boundary,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_we,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_we,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              prog_done,
  output logic [DATA_W-1:0] load_csum,
  output logic              verify_err
);

  typedef enum logic [2:0] {RUN, DRAIN, LOAD, VERIFY, DONE} state_t;

  localparam int               CNT_W   = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] ptr;
  logic [CNT_W-1:0]  cnt;
  logic              wr_pend;
  logic [DATA_W-1:0] wr_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_csum;
  logic              accept;
  logic              load_last;
  logic              issue;
  logic              verify_last;

  // cnt counts accepted bytes in LOAD and issued read addresses in VERIFY
  assign accept      = in_valid & in_ready;
  assign load_last   = (state == LOAD) && (cnt == DEPTH_C) && wr_pend;
  assign issue       = (state == VERIFY) && (cnt < DEPTH_C);
  assign verify_last = (state == VERIFY) && rd_valid && (cnt == DEPTH_C);

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:    if (prog_req) state_nxt = DRAIN;
      DRAIN: begin
        if (!prog_req)         state_nxt = RUN;
        else if (cpu_boundary) state_nxt = LOAD;
      end
      LOAD:   if (load_last)   state_nxt = VERIFY;
      VERIFY: if (verify_last) state_nxt = DONE;
      DONE:   if (!prog_req)   state_nxt = RUN;
      default:                 state_nxt = RUN;
    endcase
  end

  always_comb begin
    cpu_hold  = 1'b0;
    in_ready  = 1'b0;
    ram_addr  = cpu_addr;
    ram_wdata = cpu_wdata;
    ram_we    = cpu_we;
    case (state)
      LOAD: begin
        cpu_hold  = 1'b1;
        in_ready  = (cnt < DEPTH_C);
        ram_addr  = ptr;
        ram_wdata = wr_data;
        ram_we    = wr_pend;
      end
      VERIFY, DONE: begin
        cpu_hold  = 1'b1;
        ram_addr  = ptr;
        ram_wdata = wr_data;
        ram_we    = 1'b0;
      end
      default: ;
    endcase
  end

  // Each accepted byte is written the following cycle; readback data trails its address by one
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr         <= '0;
      cnt         <= '0;
      wr_pend     <= 1'b0;
      wr_data     <= '0;
      rd_valid    <= 1'b0;
      rd_csum     <= '0;
      load_csum   <= '0;
      verify_err  <= 1'b0;
      prog_done   <= 1'b0;
      cpu_restart <= 1'b0;
    end else begin
      prog_done   <= 1'b0;
      cpu_restart <= (state == DONE) && !prog_req;
      wr_pend     <= 1'b0;
      rd_valid    <= 1'b0;
      case (state)
        DRAIN: begin
          if (prog_req && cpu_boundary) begin
            ptr        <= '0;
            cnt        <= '0;
            load_csum  <= '0;
            verify_err <= 1'b0;
          end
        end
        LOAD: begin
          if (accept) begin
            wr_pend <= 1'b1;
            wr_data <= in_data;
            cnt     <= cnt + 1'b1;
          end
          if (wr_pend) begin
            ptr       <= ptr + 1'b1;
            load_csum <= load_csum ^ wr_data;
          end
          if (load_last) begin
            ptr     <= '0;
            cnt     <= '0;
            rd_csum <= '0;
          end
        end
        VERIFY: begin
          if (issue) begin
            ptr      <= ptr + 1'b1;
            cnt      <= cnt + 1'b1;
            rd_valid <= 1'b1;
          end
          if (rd_valid) rd_csum <= rd_csum ^ ram_rdata;
          if (verify_last) begin
            verify_err <= ((rd_csum ^ ram_rdata) != load_csum);
            prog_done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader_arbiter.sv
// Scoreboard bench for prog_loader_arbiter: models the RAM, records loader writes
// under hold and compares them to the bytes the bench pushed when each was accepted.
module tb_prog_loader_arbiter;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic       clk;
  logic       rst;
  logic       prog_req;
  logic       cpu_boundary;
  logic [3:0] cpu_addr;
  logic [7:0] cpu_wdata;
  logic       cpu_we;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] ram_rdata;
  logic [3:0] ram_addr;
  logic [7:0] ram_wdata;
  logic       ram_we;
  logic       cpu_hold;
  logic       cpu_restart;
  logic       prog_done;
  logic [7:0] load_csum;
  logic       verify_err;

  int         tests_run;
  int         tests_failed;
  logic [7:0] mem [16];
  logic [7:0] img [16];
  logic       corrupt_en;
  wr_t        exp_q [$];
  wr_t        obs_q [$];
  logic [3:0] exp_addr;
  int         obs_base;

  prog_loader_arbiter #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .prog_req(prog_req), .cpu_boundary(cpu_boundary),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .ram_rdata(ram_rdata), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we),
    .cpu_hold(cpu_hold), .cpu_restart(cpu_restart), .prog_done(prog_done),
    .load_csum(load_csum), .verify_err(verify_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read RAM; corrupt_en flips bit 0 of every read of address 3
  always @(posedge clk) begin
    if (ram_we === 1'b1) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr] ^ ((corrupt_en && ram_addr == 4'd3) ? 8'h01 : 8'h00);
  end

  always @(negedge clk)
    if (cpu_hold === 1'b1 && ram_we === 1'b1) obs_q.push_back({ram_addr, ram_wdata});

  function automatic logic [7:0] img_xor();
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 16; i++) x ^= img[i];
    return x;
  endfunction

  task automatic sb_clear();
    exp_q.delete();
    exp_addr = 4'd0;
    obs_base = obs_q.size();
  endtask

  task automatic start_load(output bit entered, output int lat);
    sb_clear();
    prog_req = 1'b1;
    cpu_boundary = 1'b1;
    entered = 1'b0;
    lat = -1;
    for (int i = 0; i < 10 && !entered; i++) begin
      @(negedge clk);
      if (cpu_hold === 1'b1) begin entered = 1'b1; lat = i; end
    end
    @(posedge clk); #1;
    cpu_boundary = 1'b0;
  endtask

  task automatic stream(input int n, input bit throttle, input int limit,
                        output int accepted, output int cycles);
    bit phase;
    phase = !throttle;
    accepted = 0;
    cycles = 0;
    while (cycles < limit && accepted < n) begin
      in_valid = phase;
      in_data = img[accepted];
      @(negedge clk);
      if (in_valid && in_ready === 1'b1) begin
        exp_q.push_back({exp_addr, img[accepted]});
        exp_addr = exp_addr + 4'd1;
        accepted++;
      end
      @(posedge clk); #1;
      cycles++;
      if (throttle) phase = !phase;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output bit seen, output bit err, output bit single);
    seen = 1'b0;
    err = 1'b0;
    for (int i = 0; i < 80 && !seen; i++) begin
      @(negedge clk);
      if (prog_done === 1'b1) begin seen = 1'b1; err = verify_err; end
    end
    @(negedge clk);
    single = (prog_done === 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic release_cpu(output bit seen, output bit hold_at, output bit single);
    prog_req = 1'b0;
    seen = 1'b0;
    hold_at = 1'b1;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (cpu_restart === 1'b1) begin seen = 1'b1; hold_at = cpu_hold; end
    end
    @(negedge clk);
    single = (cpu_restart === 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; prog_req = 1'b0; cpu_boundary = 1'b0;
    cpu_we = 1'b1; cpu_addr = 4'h5; cpu_wdata = 8'h3C; in_valid = 1'b1; in_data = 8'hFF;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (cpu_hold !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_hold: got %b want 0", cpu_hold); end
    tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_in_ready: got %b want 0", in_ready); end
    tests_run++; if ({cpu_restart, prog_done, verify_err} !== 3'b000) begin tests_failed++; $display("[TB] FAIL reset_pulses: got %b want 000", {cpu_restart, prog_done, verify_err}); end
    tests_run++; if (load_csum !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_csum: got %h want 00", load_csum); end
    tests_run++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 4'h5, 8'h3C}) begin tests_failed++; $display("[TB] FAIL reset_passthru: got %h want %h", {ram_we, ram_addr, ram_wdata}, {1'b1, 4'h5, 8'h3C}); end
    @(posedge clk); #1;
    rst = 1'b0; cpu_we = 1'b0;
    @(negedge clk);
    tests_run++; if ({cpu_hold, in_ready} !== 2'b00) begin tests_failed++; $display("[TB] FAIL run_ignores_valid: got %b want 00", {cpu_hold, in_ready}); end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic test_normal_load();
    bit ent, seen, err, single, rs, hold_at, rsingle;
    int lat, acc, cyc;
    logic [7:0] x;
    wr_t e;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) @(posedge clk); #1;
    for (int i = 0; i < 16; i++) img[i] = 8'h10 + 8'(i);
    x = img_xor();
    start_load(ent, lat);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("[TB] FAIL normal_hold_latency: got %0d want 2", lat); end
    stream(16, 1'b0, 64, acc, cyc);
    tests_run++; if (cyc !== 16) begin tests_failed++; $display("[TB] FAIL normal_throughput: got %0d cycles want 16", cyc); end
    wait_done(seen, err, single);
    tests_run++; if ({seen, single, err} !== 3'b110) begin tests_failed++; $display("[TB] FAIL normal_done: got seen/single/err %b want 110", {seen, single, err}); end
    tests_run++; if (load_csum !== x) begin tests_failed++; $display("[TB] FAIL normal_csum: got %h want %h", load_csum, x); end
    tests_run++; if (obs_q.size() - obs_base !== 16) begin tests_failed++; $display("[TB] FAIL normal_wr_count: got %0d want 16", obs_q.size() - obs_base); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      if (obs_base + k < obs_q.size()) begin
        tests_run++; if (obs_q[obs_base + k] !== e) begin tests_failed++; $display("[TB] FAIL normal_wr%0d: got %h want %h", k, obs_q[obs_base + k], e); end
      end
    end
    release_cpu(rs, hold_at, rsingle);
    tests_run++; if ({rs, hold_at, rsingle} !== 3'b101) begin tests_failed++; $display("[TB] FAIL normal_restart: got seen/hold/single %b want 101", {rs, hold_at, rsingle}); end
  endtask

  task automatic test_boundary_wait();
    bit seen, err, single, rs, hold_at, rsingle;
    int acc, cyc;
    logic [7:0] x;
    wr_t e;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    x = img_xor();
    sb_clear();
    prog_req = 1'b1;
    cpu_boundary = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cpu_we = (i % 2 == 1);
      cpu_addr = 4'(i + 3);
      cpu_wdata = 8'(i * 17 + 1);
      @(negedge clk);
      tests_run++;
      if ({cpu_hold, ram_we, ram_addr, ram_wdata} !== {1'b0, cpu_we, cpu_addr, cpu_wdata}) begin
        tests_failed++;
        $display("[TB] FAIL drain_passthru%0d: got %h want %h", i, {cpu_hold, ram_we, ram_addr, ram_wdata}, {1'b0, cpu_we, cpu_addr, cpu_wdata});
      end
      @(posedge clk); #1;
    end
    cpu_we = 1'b0;
    cpu_boundary = 1'b1;
    @(negedge clk);
    tests_run++; if (cpu_hold !== 1'b0) begin tests_failed++; $display("[TB] FAIL boundary_same_cycle: got %b want 0", cpu_hold); end
    @(posedge clk); #1;
    cpu_boundary = 1'b0;
    @(negedge clk);
    tests_run++; if (cpu_hold !== 1'b1) begin tests_failed++; $display("[TB] FAIL boundary_next_cycle: got %b want 1", cpu_hold); end
    @(posedge clk); #1;
    stream(16, 1'b0, 64, acc, cyc);
    wait_done(seen, err, single);
    tests_run++; if ({seen, err, load_csum} !== {2'b10, x}) begin tests_failed++; $display("[TB] FAIL boundary_done: got %h want %h", {seen, err, load_csum}, {2'b10, x}); end
    tests_run++; if (obs_q.size() - obs_base !== 16) begin tests_failed++; $display("[TB] FAIL boundary_wr_count: got %0d want 16", obs_q.size() - obs_base); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      if (obs_base + k < obs_q.size()) begin
        tests_run++; if (obs_q[obs_base + k] !== e) begin tests_failed++; $display("[TB] FAIL boundary_wr%0d: got %h want %h", k, obs_q[obs_base + k], e); end
      end
    end
    release_cpu(rs, hold_at, rsingle);
    tests_run++; if (rs !== 1'b1) begin tests_failed++; $display("[TB] FAIL boundary_restart: got %b want 1", rs); end
  endtask

  task automatic test_throttled();
    bit ent, seen, err, single, rs, hold_at, rsingle;
    int lat, acc, cyc;
    logic [7:0] x;
    wr_t e;
    for (int i = 0; i < 16; i++) img[i] = 8'hA5;
    x = img_xor();
    start_load(ent, lat);
    stream(16, 1'b1, 100, acc, cyc);
    tests_run++; if ({acc, cyc} !== {32'd16, 32'd32}) begin tests_failed++; $display("[TB] FAIL throttle_accepts: got %0d in %0d cycles want 16 in 32", acc, cyc); end
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests_run++; if (in_ready !== 1'b0) begin tests_failed++; $display("[TB] FAIL throttle_ready_low%0d: got %b want 0", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done(seen, err, single);
    tests_run++; if ({seen, err, load_csum} !== {2'b10, x}) begin tests_failed++; $display("[TB] FAIL throttle_done: got %h want %h", {seen, err, load_csum}, {2'b10, x}); end
    tests_run++; if (obs_q.size() - obs_base !== 16) begin tests_failed++; $display("[TB] FAIL throttle_wr_count: got %0d want 16", obs_q.size() - obs_base); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      if (obs_base + k < obs_q.size()) begin
        tests_run++; if (obs_q[obs_base + k] !== e) begin tests_failed++; $display("[TB] FAIL throttle_wr%0d: got %h want %h", k, obs_q[obs_base + k], e); end
      end
    end
    release_cpu(rs, hold_at, rsingle);
  endtask

  task automatic test_verify_failure();
    bit ent, seen, err, single, rs, hold_at, rsingle;
    int lat, acc, cyc;
    logic [7:0] x;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    x = img_xor();
    corrupt_en = 1'b1;
    start_load(ent, lat);
    stream(16, 1'b0, 64, acc, cyc);
    wait_done(seen, err, single);
    corrupt_en = 1'b0;
    tests_run++; if ({seen, single, err} !== 3'b111) begin tests_failed++; $display("[TB] FAIL verify_err_flag: got seen/single/err %b want 111", {seen, single, err}); end
    tests_run++; if (load_csum !== x) begin tests_failed++; $display("[TB] FAIL verify_csum: got %h want %h", load_csum, x); end
    release_cpu(rs, hold_at, rsingle);
    repeat (3) @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (verify_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL verify_err_sticky: got %b want 1", verify_err); end
    @(posedge clk); #1;
  endtask

  task automatic test_cancel_isolation();
    bit ent, seen, err, single, rs, hold_at, rsingle, hold_seen;
    int lat, acc, cyc;
    logic [7:0] x;
    wr_t e;
    cpu_boundary = 1'b0;
    prog_req = 1'b1;
    @(posedge clk); #1;
    prog_req = 1'b0;
    hold_seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) cpu_boundary = 1'b1;
      @(negedge clk);
      if (cpu_hold !== 1'b0) hold_seen = 1'b1;
      @(posedge clk); #1;
    end
    cpu_boundary = 1'b0;
    tests_run++; if (hold_seen !== 1'b0) begin tests_failed++; $display("[TB] FAIL cancel_hold: got %b want 0", hold_seen); end
    tests_run++; if (verify_err !== 1'b1) begin tests_failed++; $display("[TB] FAIL cancel_err_kept: got %b want 1", verify_err); end
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    x = img_xor();
    cpu_we = 1'b1; cpu_addr = 4'hF; cpu_wdata = 8'hEE;
    start_load(ent, lat);
    tests_run++; if (lat !== 2) begin tests_failed++; $display("[TB] FAIL cancel_back_in_run: got latency %0d want 2", lat); end
    tests_run++; if (verify_err !== 1'b0) begin tests_failed++; $display("[TB] FAIL load_clears_err: got %b want 0", verify_err); end
    stream(16, 1'b0, 64, acc, cyc);
    wait_done(seen, err, single);
    cpu_we = 1'b0;
    tests_run++; if ({seen, err, load_csum} !== {2'b10, x}) begin tests_failed++; $display("[TB] FAIL isolate_done: got %h want %h", {seen, err, load_csum}, {2'b10, x}); end
    tests_run++; if (obs_q.size() - obs_base !== 16) begin tests_failed++; $display("[TB] FAIL isolate_wr_count: got %0d want 16", obs_q.size() - obs_base); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      if (obs_base + k < obs_q.size()) begin
        tests_run++; if (obs_q[obs_base + k] !== e) begin tests_failed++; $display("[TB] FAIL isolate_wr%0d: got %h want %h", k, obs_q[obs_base + k], e); end
      end
    end
    tests_run++; if (mem[15] !== img[15]) begin tests_failed++; $display("[TB] FAIL isolate_ram15: got %h want %h", mem[15], img[15]); end
    release_cpu(rs, hold_at, rsingle);
  endtask

  task automatic test_back_to_back();
    bit ent, seen, err, single, rs, hold_at, rsingle;
    int lat, acc, cyc;
    logic [7:0] x;
    wr_t e;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    x = img_xor();
    start_load(ent, lat);
    stream(16, 1'b0, 64, acc, cyc);
    wait_done(seen, err, single);
    tests_run++; if ({seen, err, load_csum} !== {2'b10, x}) begin tests_failed++; $display("[TB] FAIL b2b_first_done: got %h want %h", {seen, err, load_csum}, {2'b10, x}); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      tests_run++; if ({cpu_hold, in_ready, prog_done, cpu_restart} !== 4'b1000) begin tests_failed++; $display("[TB] FAIL b2b_done_hold%0d: got %b want 1000", i, {cpu_hold, in_ready, prog_done, cpu_restart}); end
      @(posedge clk); #1;
    end
    prog_req = 1'b0;
    @(posedge clk); #1;
    prog_req = 1'b1;
    cpu_boundary = 1'b1;
    @(negedge clk);
    tests_run++; if ({cpu_restart, cpu_hold} !== 2'b10) begin tests_failed++; $display("[TB] FAIL b2b_restart: got %b want 10", {cpu_restart, cpu_hold}); end
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    x = img_xor();
    start_load(ent, lat);
    tests_run++; if (ent !== 1'b1) begin tests_failed++; $display("[TB] FAIL b2b_second_entry: got %b want 1", ent); end
    stream(16, 1'b0, 64, acc, cyc);
    wait_done(seen, err, single);
    tests_run++; if ({seen, err, load_csum} !== {2'b10, x}) begin tests_failed++; $display("[TB] FAIL b2b_second_done: got %h want %h", {seen, err, load_csum}, {2'b10, x}); end
    tests_run++; if (obs_q.size() - obs_base !== 16) begin tests_failed++; $display("[TB] FAIL b2b_wr_count: got %0d want 16", obs_q.size() - obs_base); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      if (obs_base + k < obs_q.size()) begin
        tests_run++; if (obs_q[obs_base + k] !== e) begin tests_failed++; $display("[TB] FAIL b2b_wr%0d: got %h want %h", k, obs_q[obs_base + k], e); end
      end
    end
    release_cpu(rs, hold_at, rsingle);
  endtask

  task automatic test_reset_mid_load();
    bit ent, bad;
    int lat, acc, cyc;
    wr_t e;
    for (int i = 0; i < 16; i++) img[i] = 8'($urandom);
    start_load(ent, lat);
    stream(5, 1'b0, 20, acc, cyc);
    tests_run++; if (acc !== 5) begin tests_failed++; $display("[TB] FAIL rstmid_accepts: got %0d want 5", acc); end
    rst = 1'b1;
    cpu_we = 1'b1; cpu_addr = 4'h9; cpu_wdata = 8'h77; in_valid = 1'b1; in_data = 8'h55;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if ({cpu_hold, in_ready, cpu_restart} !== 3'b000) begin tests_failed++; $display("[TB] FAIL rstmid_state: got %b want 000", {cpu_hold, in_ready, cpu_restart}); end
    tests_run++; if ({ram_we, ram_addr, ram_wdata} !== {1'b1, 4'h9, 8'h77}) begin tests_failed++; $display("[TB] FAIL rstmid_passthru: got %h want %h", {ram_we, ram_addr, ram_wdata}, {1'b1, 4'h9, 8'h77}); end
    tests_run++; if (load_csum !== 8'h00) begin tests_failed++; $display("[TB] FAIL rstmid_csum: got %h want 00", load_csum); end
    bad = 1'b0;
    prog_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if ({cpu_hold, in_ready, cpu_restart} !== 3'b000) bad = 1'b1;
    end
    @(posedge clk); #1;
    cpu_we = 1'b0; in_valid = 1'b0;
    tests_run++; if (bad !== 1'b0) begin tests_failed++; $display("[TB] FAIL rstmid_quiet: got %b want 0", bad); end
    tests_run++; if (obs_q.size() - obs_base !== 5) begin tests_failed++; $display("[TB] FAIL rstmid_wr_count: got %0d want 5", obs_q.size() - obs_base); end
    for (int k = 0; exp_q.size() > 0; k++) begin
      e = exp_q.pop_front();
      if (obs_base + k < obs_q.size()) begin
        tests_run++; if (obs_q[obs_base + k] !== e) begin tests_failed++; $display("[TB] FAIL rstmid_wr%0d: got %h want %h", k, obs_q[obs_base + k], e); end
      end
    end
    tests_run++; if (mem[4] !== img[4]) begin tests_failed++; $display("[TB] FAIL rstmid_ram_kept: got %h want %h", mem[4], img[4]); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    corrupt_en = 1'b0;
    rst = 1'b1;
    prog_req = 1'b0;
    cpu_boundary = 1'b0;
    cpu_addr = 4'h0;
    cpu_wdata = 8'h00;
    cpu_we = 1'b0;
    in_valid = 1'b0;
    in_data = 8'h00;
    exp_addr = 4'd0;
    obs_base = 0;
    test_reset();
    test_normal_load();
    test_boundary_wait();
    test_throttled();
    test_verify_failure();
    test_cancel_isolation();
    test_back_to_back();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/prog_loader_arbiter.md
Name: prog_loader_arbiter

Overview:
- Sequences loading of a program image into the 16-byte RAM of the 8-bit CPU and arbitrates RAM ownership between the CPU datapath and an external byte-stream loader.
- Waits for the CPU to reach an instruction boundary, then holds it by driving the decoder's prog_mode.
- Writes DEPTH bytes, verifies them with a readback checksum, releases the CPU and requests a restart.

Parameters:
ADDR_W, 4, RAM address width
DATA_W, 8, RAM/bus data width
DEPTH, 16, bytes per image; 1 <= DEPTH <= 2**ADDR_W

Ports:
clk  in  1  system clock; all state changes on rising edge
rst  in  1  synchronous reset, active-high
prog_req  in  1  level request to load a new image
cpu_boundary  in  1  high when the CPU micro-step counter is 0 (fetch start)
cpu_addr  in  ADDR_W  CPU memory address register
cpu_wdata  in  DATA_W  CPU bus value for RAM writes
cpu_we  in  1  CPU RAM write strobe (ri)
in_valid  in  1  loader byte valid
in_data  in  DATA_W  loader byte
in_ready  out  1  loader byte accepted when in_valid & in_ready
ram_rdata  in  DATA_W  RAM read data; valid one cycle after address
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_we  out  1  RAM write enable
cpu_hold  out  1  drives decoder prog_mode; CPU frozen while high
cpu_restart  out  1  one-cycle pulse requesting CPU reset on release
prog_done  out  1  one-cycle pulse at end of verify
load_csum  out  DATA_W  XOR of all bytes accepted in last load
verify_err  out  1  sticky; readback checksum != load_csum

Behaviour:
- States: RUN, DRAIN, LOAD, VERIFY, DONE.
- Reset values: state=RUN, pointer=0, cpu_hold=0, in_ready=0, ram_we (loader)=0, cpu_restart=0, prog_done=0, load_csum=0, verify_err=0.
- RAM mux in RUN/DRAIN: ram_addr=cpu_addr, ram_wdata=cpu_wdata, ram_we=cpu_we (combinational pass-through).
- RAM mux in LOAD/VERIFY/DONE: loader registers drive the RAM; cpu_we is ignored.
- RUN: prog_req=1 -> DRAIN.
- DRAIN: prog_req=0 -> RUN (cancel).
- DRAIN: prog_req=1 & cpu_boundary=1 -> LOAD. cpu_hold=1 from the first LOAD cycle. Pointer and load_csum clear to 0; verify_err clears.
- LOAD: in_ready=1 while accepted count < DEPTH.
- LOAD accept: the byte is registered and written in the next cycle (ram_we=1, ram_addr=pointer, ram_wdata=byte). The pointer then increments and load_csum ^= byte.
- LOAD throughput: one byte per cycle; back-to-back accepts are legal.
- LOAD end: after the DEPTH-th accept, in_ready=0 the next cycle. Once the final write completes -> VERIFY with pointer=0.
- VERIFY issue: drives ram_addr=0..DEPTH-1 on consecutive cycles, ram_we=0.
- VERIFY capture: ram_rdata is captured one cycle after each address into a running XOR that starts at 0.
- VERIFY end: after the DEPTH-th capture, verify_err=(readback XOR != load_csum), then -> DONE. prog_done pulses 1 cycle on entry to DONE.
- DONE: cpu_hold stays 1 while prog_req=1.
- DONE -> RUN: when prog_req=0, cpu_restart pulses 1 cycle on the transition and cpu_hold=0 in the same cycle as RUN entry.
- prog_req deassert during LOAD or VERIFY is ignored; the sequence always completes.
- prog_req held high through DONE does not start a second load until it has been seen low in DONE.
- in_valid outside LOAD is ignored and in_ready stays 0.
- rst mid-operation: returns to RUN immediately with cpu_hold=0 and no restart pulse. A partially loaded RAM is left as is.
- Pointer width ADDR_W. The pointer never wraps within a load because DEPTH <= 2**ADDR_W.

Test Plan:
- Normal load: rst, then prog_req=1 with cpu_boundary=1 at cycle 5. Stream bytes 0x10..0x1F back-to-back -> exactly 16 ram_we pulses at addresses 0..15, load_csum=0x00, prog_done pulse, verify_err=0. After prog_req=0: cpu_restart pulse and cpu_hold=0.
- Boundary wait: prog_req=1 with cpu_boundary=0 for 7 cycles -> cpu_hold=0 and ram_we follows cpu_we throughout. cpu_hold=1 in the cycle after cpu_boundary=1.
- Throttled stream: in_valid toggles every other cycle with data 0xA5 x16 -> 16 writes, load_csum=0x00, in_ready=0 after the 16th accept.
- Verify failure: force ram_rdata at address 3 to be corrupted (XOR 0x01) during VERIFY -> verify_err=1 with prog_done pulse. verify_err stays 1 until the next load starts.
- Cancel and isolation: prog_req pulses 1 cycle while cpu_boundary=0 -> DRAIN returns to RUN, no hold. Assert cpu_we=1 during LOAD -> no CPU write reaches the RAM.
- Reset mid-load: rst after 5 bytes -> cpu_hold=0, in_ready=0, and RUN pass-through restored next cycle with no cpu_restart pulse.
